writeback_scoreboard: RTL and testbench
=======================================

WRITEBACK_SCOREBOARD -- requirements
Module: writeback_scoreboard

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the result data width.
REQ-002 SHALL have parameter REG_INDEX_BITS, default 5, the architectural register index width.
REQ-003 SHALL have parameter THREAD_INDEX_BITS, default 3, the hardware thread index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_write_back_flag  input  1  mem2 result valid and targets a register.
REQ-007 SHALL have port in_reg_index  input  REG_INDEX_BITS  destination register of the mem2 result.
REQ-008 SHALL have port in_thread_index  input  THREAD_INDEX_BITS  thread of the mem2 result.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  mem2 result data.
REQ-010 SHALL have port issue_flag  input  1  issue stage requests to dispatch a register-writing instruction.
REQ-011 SHALL have port issue_reg_index  input  REG_INDEX_BITS  destination register of the issuing instruction.
REQ-012 SHALL have port issue_thread_index  input  THREAD_INDEX_BITS  thread of the issuing instruction.
REQ-013 SHALL have port issue_stall  output  1  combinational; issue refused this cycle (WAW).
REQ-014 SHALL have port query_thread_index  input  THREAD_INDEX_BITS  thread for decode operand queries.
REQ-015 SHALL have ports query_reg_index_a / query_reg_index_b  input  REG_INDEX_BITS  decode source operands.
REQ-016 SHALL have ports query_busy_a / query_busy_b  output  1  combinational; operand not yet readable from register file.
REQ-017 SHALL have ports rf_we (1), rf_waddr_reg (REG_INDEX_BITS), rf_waddr_thread (THREAD_INDEX_BITS), rf_wdata (DATA_WIDTH), all outputs, registered register-file write port.
REQ-018 SHALL have port sb_error  output  1  sticky: writeback arrived for a non-busy register.

Function
REQ-019 SHALL register one cycle: rf_we <= in_write_back_flag AND in_reg_index != 0; rf_waddr_reg/rf_waddr_thread/rf_wdata <= in_* whenever in_write_back_flag is 1, else hold.
REQ-020 SHALL keep busy[thread][reg], 2^THREAD_INDEX_BITS x 2^REG_INDEX_BITS bits; register 0 bit constant 0.
REQ-021 SHALL compute pend(t,r) = busy[t][r] OR (rf_we AND rf_waddr_thread==t AND rf_waddr_reg==r).
REQ-022 SHALL drive query_busy_x = pend(query_thread_index, query_reg_index_x); 0 when index is 0.
REQ-023 SHALL drive issue_stall = issue_flag AND issue_reg_index != 0 AND pend(issue_thread_index, issue_reg_index).
REQ-024 SHALL set busy bit at the edge when issue_flag=1, issue_stall=0, issue_reg_index!=0.
REQ-025 SHALL clear busy bit at the edge when in_write_back_flag=1 and in_reg_index!=0 (same edge rf_we rises).
REQ-026 SHALL, when set and clear target the same bit on one edge, leave the bit set and set sb_error.
REQ-027 SHALL set sb_error on any writeback (reg!=0) whose busy bit is 0; sb_error clears only by reset.
REQ-028 SHALL ignore issue and writeback to register 0 for scoreboard purposes; no rf_we, no error.

Reset
REQ-029 SHALL, while reset=0, asynchronously force rf_we=0, rf_waddr_reg=0, rf_waddr_thread=0, rf_wdata=0, all busy=0, sb_error=0, retire_count=0.
REQ-030 SHALL discard in-flight writebacks when reset asserts mid-operation; first update on first rising clk after reset=1.

Configuration
REQ-031 SHALL, with WB_RETIRE_COUNT_EN defined, add output retire_count (32 bits) incremented by 1 per edge with in_write_back_flag=1 (any register), wrapping 0xFFFFFFFF->0.
REQ-032 SHALL, without WB_RETIRE_COUNT_EN, omit retire_count port and counter entirely.

Structure
REQ-033 SHALL take DATA_WIDTH, REG_INDEX_BITS, THREAD_INDEX_BITS defaults and thread/register index typedefs from shared package pipeline_pkg.
REQ-034 SHALL place the busy array with set/clear/lookup in sub-module wb_scoreboard_bits; write port and error/counter logic in top.

Verification
REQ-035 SHALL test: issue t2 r5, next cycle writeback t2 r5 data 0xDEAD -> query_busy 1 until rf_we cycle, rf_we=1 rf_wdata=0xDEAD one cycle after input, busy 0 after that.
REQ-036 SHALL test: issue t1 r7 twice back-to-back -> second issue_stall=1, busy set once.
REQ-037 SHALL test: writeback t3 r9 never issued -> sb_error=1 and held; issue t3 r9 same cycle -> bit stays set.
REQ-038 SHALL test: issue/writeback r0 -> no stall, no rf_we, query_busy 0, no error.
REQ-039 SHALL test: reset=0 asserted between clk edges with busy bits set -> all outputs 0 immediately, without clk.
REQ-040 SHALL test (WB_RETIRE_COUNT_EN): preload count 0xFFFFFFFE, three writebacks -> count 0x00000001.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline sizing defaults and index typedefs used by the writeback scoreboard and its users.
package pipeline_pkg;

    localparam int unsigned DEF_DATA_WIDTH        = 64;
    localparam int unsigned DEF_REG_INDEX_BITS    = 5;
    localparam int unsigned DEF_THREAD_INDEX_BITS = 3;

    typedef logic [DEF_REG_INDEX_BITS-1:0]    reg_index_t;
    typedef logic [DEF_THREAD_INDEX_BITS-1:0] thread_index_t;
    typedef logic [DEF_DATA_WIDTH-1:0]        data_t;

endpackage

// File: rtl/wb_scoreboard_bits.sv
// Per-thread, per-register busy bit array with set/clear ports and combinational lookups.
module wb_scoreboard_bits
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_INDEX_BITS    = DEF_REG_INDEX_BITS,
    parameter int unsigned THREAD_INDEX_BITS = DEF_THREAD_INDEX_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         set_en,
    input  logic [THREAD_INDEX_BITS-1:0] set_thread,
    input  logic [REG_INDEX_BITS-1:0]    set_reg,
    input  logic                         clr_en,
    input  logic [THREAD_INDEX_BITS-1:0] clr_thread,
    input  logic [REG_INDEX_BITS-1:0]    clr_reg,
    input  logic [THREAD_INDEX_BITS-1:0] query_thread,
    input  logic [REG_INDEX_BITS-1:0]    query_reg_a,
    input  logic [REG_INDEX_BITS-1:0]    query_reg_b,
    output logic                         busy_a,
    output logic                         busy_b,
    output logic                         busy_set,
    output logic                         busy_clr
);

    localparam int unsigned NUM_THREADS = 1 << THREAD_INDEX_BITS;
    localparam int unsigned NUM_REGS    = 1 << REG_INDEX_BITS;

    logic [NUM_THREADS-1:0][NUM_REGS-1:0] busy;

    // Set is applied after clear so a same-edge collision leaves the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (clr_en && clr_reg != '0) begin
                busy[clr_thread][clr_reg] <= 1'b0;
            end
            if (set_en && set_reg != '0) begin
                busy[set_thread][set_reg] <= 1'b1;
            end
        end
    end

    always_comb begin
        busy_a   = busy[query_thread][query_reg_a];
        busy_b   = busy[query_thread][query_reg_b];
        busy_set = busy[set_thread][set_reg];
        busy_clr = busy[clr_thread][clr_reg];
    end

endmodule

// File: rtl/writeback_scoreboard.sv
// Writeback stage: registered register-file write port plus WAW/RAW scoreboard and sticky error.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_scoreboard
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int unsigned REG_INDEX_BITS    = DEF_REG_INDEX_BITS,
    parameter int unsigned THREAD_INDEX_BITS = DEF_THREAD_INDEX_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_write_back_flag,
    input  logic [REG_INDEX_BITS-1:0]    in_reg_index,
    input  logic [THREAD_INDEX_BITS-1:0] in_thread_index,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         issue_flag,
    input  logic [REG_INDEX_BITS-1:0]    issue_reg_index,
    input  logic [THREAD_INDEX_BITS-1:0] issue_thread_index,
    output logic                         issue_stall,
    input  logic [THREAD_INDEX_BITS-1:0] query_thread_index,
    input  logic [REG_INDEX_BITS-1:0]    query_reg_index_a,
    input  logic [REG_INDEX_BITS-1:0]    query_reg_index_b,
    output logic                         query_busy_a,
    output logic                         query_busy_b,
    output logic                         rf_we,
    output logic [REG_INDEX_BITS-1:0]    rf_waddr_reg,
    output logic [THREAD_INDEX_BITS-1:0] rf_waddr_thread,
    output logic [DATA_WIDTH-1:0]        rf_wdata,
    output logic                         sb_error
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [31:0]                  retire_count
`endif
);

    logic wb_valid;
    logic issue_valid;
    logic set_en;
    logic bit_busy_a;
    logic bit_busy_b;
    logic bit_busy_issue;
    logic bit_busy_wb;

    // The register file is written one cycle after the busy bit clears, so the
    // in-flight write still counts as pending for readers and issuers.
    function automatic logic write_pending(input logic [THREAD_INDEX_BITS-1:0] t,
                                           input logic [REG_INDEX_BITS-1:0]    r);
        return rf_we && (rf_waddr_thread == t) && (rf_waddr_reg == r);
    endfunction

    always_comb begin
        wb_valid     = in_write_back_flag && (in_reg_index != '0);
        issue_valid  = issue_flag && (issue_reg_index != '0);
        issue_stall  = issue_valid &&
                       (bit_busy_issue || write_pending(issue_thread_index, issue_reg_index));
        set_en       = issue_valid && !issue_stall;
        query_busy_a = (query_reg_index_a != '0) &&
                       (bit_busy_a || write_pending(query_thread_index, query_reg_index_a));
        query_busy_b = (query_reg_index_b != '0) &&
                       (bit_busy_b || write_pending(query_thread_index, query_reg_index_b));
    end

    wb_scoreboard_bits #(
        .REG_INDEX_BITS    (REG_INDEX_BITS),
        .THREAD_INDEX_BITS (THREAD_INDEX_BITS)
    ) u_bits (
        .clk          (clk),
        .reset        (reset),
        .set_en       (set_en),
        .set_thread   (issue_thread_index),
        .set_reg      (issue_reg_index),
        .clr_en       (wb_valid),
        .clr_thread   (in_thread_index),
        .clr_reg      (in_reg_index),
        .query_thread (query_thread_index),
        .query_reg_a  (query_reg_index_a),
        .query_reg_b  (query_reg_index_b),
        .busy_a       (bit_busy_a),
        .busy_b       (bit_busy_b),
        .busy_set     (bit_busy_issue),
        .busy_clr     (bit_busy_wb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we           <= 1'b0;
            rf_waddr_reg    <= '0;
            rf_waddr_thread <= '0;
            rf_wdata        <= '0;
            sb_error        <= 1'b0;
        end else begin
            rf_we <= wb_valid;
            if (in_write_back_flag) begin
                rf_waddr_reg    <= in_reg_index;
                rf_waddr_thread <= in_thread_index;
                rf_wdata        <= in_data;
            end
            if (wb_valid && !bit_busy_wb) begin
                sb_error <= 1'b1;
            end
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_count <= '0;
        end else if (in_write_back_flag) begin
            retire_count <= retire_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Randomized and directed checks of writeback_scoreboard against an array-based reference model.
// Define WB_RETIRE_COUNT_EN to also cover the retire counter.
module tb_writeback_scoreboard;
    import pipeline_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_write_back_flag;
    reg_index_t    in_reg_index;
    thread_index_t in_thread_index;
    data_t         in_data;
    logic          issue_flag;
    reg_index_t    issue_reg_index;
    thread_index_t issue_thread_index;
    logic          issue_stall;
    thread_index_t query_thread_index;
    reg_index_t    query_reg_index_a;
    reg_index_t    query_reg_index_b;
    logic          query_busy_a;
    logic          query_busy_b;
    logic          rf_we;
    reg_index_t    rf_waddr_reg;
    thread_index_t rf_waddr_thread;
    data_t         rf_wdata;
    logic          sb_error;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0]   retire_count;
`endif

    writeback_scoreboard #(
        .DATA_WIDTH        (DEF_DATA_WIDTH),
        .REG_INDEX_BITS    (DEF_REG_INDEX_BITS),
        .THREAD_INDEX_BITS (DEF_THREAD_INDEX_BITS)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_write_back_flag (in_write_back_flag),
        .in_reg_index       (in_reg_index),
        .in_thread_index    (in_thread_index),
        .in_data            (in_data),
        .issue_flag         (issue_flag),
        .issue_reg_index    (issue_reg_index),
        .issue_thread_index (issue_thread_index),
        .issue_stall        (issue_stall),
        .query_thread_index (query_thread_index),
        .query_reg_index_a  (query_reg_index_a),
        .query_reg_index_b  (query_reg_index_b),
        .query_busy_a       (query_busy_a),
        .query_busy_b       (query_busy_b),
        .rf_we              (rf_we),
        .rf_waddr_reg       (rf_waddr_reg),
        .rf_waddr_thread    (rf_waddr_thread),
        .rf_wdata           (rf_wdata),
        .sb_error           (sb_error)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .retire_count       (retire_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a plain 2-D array of outstanding writes plus the last register-file write.
    bit          busy_m [8][32];
    bit          we_m;
    int          wt_m;
    int          wr_m;
    data_t       wd_m;
    bit          err_m;
    logic [31:0] cnt_m;

    task automatic model_reset();
        foreach (busy_m[t, r]) busy_m[t][r] = 1'b0;
        we_m  = 1'b0;
        wt_m  = 0;
        wr_m  = 0;
        wd_m  = '0;
        err_m = 1'b0;
        cnt_m = '0;
    endtask

    function automatic bit pend(input int t, input int r);
        if (r == 0) return 1'b0;
        return busy_m[t][r] || (we_m && wt_m == t && wr_m == r);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_write_back_flag = 1'b0;
        in_reg_index       = '0;
        in_thread_index    = '0;
        in_data            = '0;
        issue_flag         = 1'b0;
        issue_reg_index    = '0;
        issue_thread_index = '0;
        query_thread_index = '0;
        query_reg_index_a  = '0;
        query_reg_index_b  = '0;
    endtask

    // Entered just after a rising edge with inputs already driven; returns just after the next one.
    task automatic step();
        bit stall_e;
        int t, r, it, ir;
        #1;
        t  = int'(in_thread_index);
        r  = int'(in_reg_index);
        it = int'(issue_thread_index);
        ir = int'(issue_reg_index);
        stall_e = issue_flag && pend(it, ir);
        chk("issue_stall", 64'(issue_stall), 64'(stall_e));
        chk("query_busy_a", 64'(query_busy_a),
            64'(pend(int'(query_thread_index), int'(query_reg_index_a))));
        chk("query_busy_b", 64'(query_busy_b),
            64'(pend(int'(query_thread_index), int'(query_reg_index_b))));
        @(posedge clk);
        if (in_write_back_flag && r != 0) begin
            if (!busy_m[t][r]) err_m = 1'b1;
            busy_m[t][r] = 1'b0;
        end
        if (issue_flag && ir != 0 && !stall_e) busy_m[it][ir] = 1'b1;
        we_m = in_write_back_flag && r != 0;
        if (in_write_back_flag) begin
            wt_m  = t;
            wr_m  = r;
            wd_m  = in_data;
            cnt_m = cnt_m + 32'd1;
        end
        #1;
        chk("rf_we", 64'(rf_we), 64'(we_m));
        chk("rf_waddr_reg", 64'(rf_waddr_reg), 64'(wr_m));
        chk("rf_waddr_thread", 64'(rf_waddr_thread), 64'(wt_m));
        chk("rf_wdata", 64'(rf_wdata), 64'(wd_m));
        chk("sb_error", 64'(sb_error), 64'(err_m));
`ifdef WB_RETIRE_COUNT_EN
        chk("retire_count", 64'(retire_count), 64'(cnt_m));
`endif
    endtask

    // Writebacks only target registers the model holds busy (or r0), so sb_error must stay low.
    task automatic random_phase(input int n);
        int cand_t[$];
        int cand_r[$];
        int k;
        for (int i = 0; i < n; i++) begin
            idle();
            cand_t.delete();
            cand_r.delete();
            for (int t = 0; t < 4; t++)
                for (int r = 1; r < 8; r++)
                    if (busy_m[t][r]) begin
                        cand_t.push_back(t);
                        cand_r.push_back(r);
                    end
            if ($urandom_range(0, 9) < 4 && cand_t.size() > 0) begin
                k = int'($urandom_range(0, cand_t.size() - 1));
                in_write_back_flag = 1'b1;
                in_thread_index    = thread_index_t'(cand_t[k]);
                in_reg_index       = reg_index_t'(cand_r[k]);
                in_data            = {$urandom, $urandom};
            end else if ($urandom_range(0, 9) == 0) begin
                in_write_back_flag = 1'b1;
                in_thread_index    = thread_index_t'($urandom_range(0, 7));
                in_reg_index       = '0;
                in_data            = {$urandom, $urandom};
            end
            issue_flag         = 1'($urandom_range(0, 1));
            issue_thread_index = thread_index_t'($urandom_range(0, 3));
            issue_reg_index    = reg_index_t'($urandom_range(0, 7));
            query_thread_index = thread_index_t'($urandom_range(0, 3));
            query_reg_index_a  = reg_index_t'($urandom_range(0, 7));
            query_reg_index_b  = reg_index_t'($urandom_range(0, 7));
            step();
        end
    endtask

    initial begin
        idle();
        model_reset();
        #3;
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_sb_error", 64'(sb_error), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Issue t2 r5, then write it back with 0xDEAD.
        idle();
        issue_flag = 1'b1; issue_thread_index = 3'd2; issue_reg_index = 5'd5;
        query_thread_index = 3'd2; query_reg_index_a = 5'd5;
        #1 chk("t2r5_busy_before_issue", 64'(query_busy_a), 64'd0);
        step();
        idle();
        in_write_back_flag = 1'b1; in_thread_index = 3'd2; in_reg_index = 5'd5;
        in_data = 64'hDEAD;
        query_thread_index = 3'd2; query_reg_index_a = 5'd5;
        #1 chk("t2r5_busy_after_issue", 64'(query_busy_a), 64'd1);
        step();
        chk("t2r5_rf_we", 64'(rf_we), 64'd1);
        chk("t2r5_rf_wdata", 64'(rf_wdata), 64'hDEAD);
        idle();
        query_thread_index = 3'd2; query_reg_index_a = 5'd5;
        #1 chk("t2r5_busy_rf_we_cycle", 64'(query_busy_a), 64'd1);
        step();
        chk("t2r5_rf_we_drop", 64'(rf_we), 64'd0);
        #1 chk("t2r5_busy_cleared", 64'(query_busy_a), 64'd0);

        // Back-to-back issue of t1 r7: second is a WAW stall.
        idle();
        issue_flag = 1'b1; issue_thread_index = 3'd1; issue_reg_index = 5'd7;
        #1 chk("t1r7_first_stall", 64'(issue_stall), 64'd0);
        step();
        #1 chk("t1r7_second_stall", 64'(issue_stall), 64'd1);
        step();
        idle();
        in_write_back_flag = 1'b1; in_thread_index = 3'd1; in_reg_index = 5'd7;
        in_data = 64'h7777;
        step();
        idle();
        step();
        query_thread_index = 3'd1; query_reg_index_b = 5'd7;
        #1 chk("t1r7_busy_once", 64'(query_busy_b), 64'd0);
        chk("t1r7_no_error", 64'(sb_error), 64'd0);

        // Register 0 is invisible to the scoreboard.
        idle();
        issue_flag = 1'b1;
        in_write_back_flag = 1'b1; in_data = 64'h1234;
        #1 chk("r0_stall", 64'(issue_stall), 64'd0);
        chk("r0_query", 64'(query_busy_a), 64'd0);
        step();
        chk("r0_rf_we", 64'(rf_we), 64'd0);
        chk("r0_error", 64'(sb_error), 64'd0);

        random_phase(300);

        // Unissued writeback t3 r9 with a same-cycle issue of t3 r9.
        idle();
        in_write_back_flag = 1'b1; in_thread_index = 3'd3; in_reg_index = 5'd9;
        in_data = 64'h9999;
        issue_flag = 1'b1; issue_thread_index = 3'd3; issue_reg_index = 5'd9;
        #1 chk("t3r9_issue_stall", 64'(issue_stall), 64'd0);
        step();
        chk("t3r9_error_set", 64'(sb_error), 64'd1);
        idle();
        query_thread_index = 3'd3; query_reg_index_a = 5'd9;
        step();
        step();
        chk("t3r9_bit_stays_set", 64'(query_busy_a), 64'd1);
        chk("t3r9_error_held", 64'(sb_error), 64'd1);

        // Asynchronous reset between edges with t3 r9 still busy.
        idle();
        query_thread_index = 3'd3; query_reg_index_a = 5'd9;
        issue_flag = 1'b1; issue_thread_index = 3'd3; issue_reg_index = 5'd9;
        in_write_back_flag = 1'b1; in_thread_index = 3'd2; in_reg_index = 5'd4;
        in_data = 64'hABCD;
        #2 reset = 1'b0;
        #1;
        chk("arst_rf_we", 64'(rf_we), 64'd0);
        chk("arst_waddr_reg", 64'(rf_waddr_reg), 64'd0);
        chk("arst_waddr_thread", 64'(rf_waddr_thread), 64'd0);
        chk("arst_wdata", 64'(rf_wdata), 64'd0);
        chk("arst_sb_error", 64'(sb_error), 64'd0);
        chk("arst_query_busy", 64'(query_busy_a), 64'd0);
        chk("arst_issue_stall", 64'(issue_stall), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_held_rf_we", 64'(rf_we), 64'd0);
        chk("arst_held_wdata", 64'(rf_wdata), 64'd0);
        reset = 1'b1;

        random_phase(100);

`ifdef WB_RETIRE_COUNT_EN
        idle();
        #1 dut.retire_count = 32'hFFFF_FFFE;
        cnt_m = 32'hFFFF_FFFE;
        in_write_back_flag = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("retire_wrap", 64'(retire_count), 64'h0000_0001);
`endif

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
